i2c_reg_seq: RTL and testbench
==============================

Name: i2c_reg_seq

Overview:
- Transaction sequencer directly upstream of i2c_master_sv.
- Accepts one register-level request (write or random read) on a valid/ready port.
- Expands the request into the byte-command sequence on the master's command handshake: start, address, register, data or repeated-start/read, stop.
- Checks acknowledges and reports completion, read data and an error code to the host logic.

Parameters:
- TIMEOUT, 65535, max clk cycles waiting for tx_rx_req_ack per command before abort.
- TW, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- div  in  10  SCL divider, latched at request accept, driven on comp
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted when req_valid&req_ready
- req_rw  in  1  0 = write, 1 = read
- req_chip  in  7  7-bit slave address
- req_reg  in  8  register/memory address
- req_wdata  in  8  write data
- done  out  1  one-cycle completion pulse
- err  out  2  0 ok, 1 address NACK, 2 reg/data NACK, 3 timeout; valid with done, held until next accept
- rd_data  out  8  read byte; valid with done when req_rw=1 and err=0, held
- comp  out  10  to master
- start_gen  out  1  to master
- stop_gen  out  1  to master
- tr_gen  out  1  to master
- rec_gen  out  1  to master
- tx_data  out  8  to master
- tr_en  out  1  to master, high from accept until done
- ack_nack  out  1  to master, ACK level driven after a received byte; always 1 (NACK) for the single read
- tx_rx_req  out  1  to master, command request
- rx_data  in  8  from master
- ack_nack_f  in  1  from master, 1 = slave NACKed last transmitted byte
- tx_rx_req_ack  in  1  from master, command complete

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0 except req_ready = 1; comp = 0; timeout counter cleared. Reset mid-transaction drops tx_rx_req immediately; no stop is issued.
- Command handshake:
  - Sequencer drives exactly one of start_gen/stop_gen/tr_gen/rec_gen plus tx_data, and asserts tx_rx_req.
  - All are held stable until a rising edge of tx_rx_req_ack. The edge is detected against a registered copy; a level that is already high on entry is ignored.
  - On the edge, in the same clock: tx_rx_req and all *_gen drop; ack_nack_f and rx_data are sampled.
  - Next command is issued no earlier than the following cycle, so tx_rx_req is low for at least 1 cycle between commands.
- FSM states: IDLE, START, ADDR_W, REG, DATA_W, RSTART, ADDR_R, READ, STOP, DONE. Each non-IDLE command state has an ISSUE and a WAIT phase.
- Write path: START -> ADDR_W (tx_data = {chip,0}) -> REG (tx_data = reg) -> DATA_W (tx_data = wdata) -> STOP -> DONE.
- Read path: START -> ADDR_W -> REG -> RSTART (start_gen again) -> ADDR_R (tx_data = {chip,1}) -> READ (rec_gen, ack_nack = 1) -> STOP -> DONE.
- NACK handling (ack_nack_f = 1 after any tr_gen command):
  - after ADDR_W or ADDR_R: err latch = 1;
  - after REG or DATA_W: err latch = 2;
  - in both cases go to STOP (the bus is always released).
- Timeout:
  - counter resets on each ISSUE and increments in WAIT;
  - on reaching TIMEOUT: err = 3, tx_rx_req drops, go to DONE without STOP.
  - A timeout during STOP also gives err = 3.
- DONE: done = 1 for one cycle, tr_en drops, return to IDLE with req_ready = 1 in the next cycle. Back-to-back requests therefore have at least 1 idle cycle.
- req_valid while busy: ignored; the host holds it.
- Request fields are captured at accept; later changes to the inputs have no effect.
- Latency (master acks in 1 cycle): write = 5 commands; read = 7 commands.

Decomposition:
- Package i2c_seq_pkg holds:
  - state enum seq_state_t;
  - error codes ERR_OK/ERR_ADDR/ERR_DATA/ERR_TMO;
  - localparams RW_WRITE = 0 / RW_READ = 1.
- No sub-module: single FSM module; the ack edge detector and timeout counter are inline.

Test Plan:
- Write, chip 0x18, reg 0x05, data 0xA7, with i2c_mem_slave (chip_addr 48) on the bus -> done, err = 0; slave mem[5] = 0xA7; command order start, tr 0x30, tr 0x05, tr 0xA7, stop.
- Read back reg 0x05 -> command order start, tr 0x30, tr 0x05, start, tr 0x31, rec with ack_nack = 1, stop; done, err = 0, rd_data = 0xA7.
- Write to absent chip 0x22 -> ADDR_W NACK, then stop issued; done with err = 1; REG never issued.
- Stub master that never acks, TIMEOUT = 100 -> done exactly 101 cycles after the START ISSUE, err = 3, tx_rx_req = 0.
- Assert reset during the REG WAIT phase -> same cycle: tx_rx_req = 0, tr_en = 0, req_ready = 1. After release, a new write completes with err = 0.
- Stub master holding tx_rx_req_ack high continuously -> no command completes without a fresh rising edge; the stub pulsing ack per command gives 5 commands for a write, each separated by at least 1 cycle of tx_rx_req = 0.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-level transaction sequencer.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR_W,
    REG,
    DATA_W,
    RSTART,
    ADDR_R,
    READ,
    STOP,
    DONE
  } seq_state_t;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_ADDR = 2'd1;
  localparam logic [1:0] ERR_DATA = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_reg_seq.sv
// Expands one register write / random read request into the byte-command
// sequence of an I2C master and reports completion, read data and errors.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT = 65535,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] div,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_chip,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] rd_data,
  output logic [9:0] comp,
  output logic       start_gen,
  output logic       stop_gen,
  output logic       tr_gen,
  output logic       rec_gen,
  output logic [7:0] tx_data,
  output logic       tr_en,
  output logic       ack_nack,
  output logic       tx_rx_req,
  input  logic [7:0] rx_data,
  input  logic       ack_nack_f,
  input  logic       tx_rx_req_ack
);

  seq_state_t    state, state_nxt;
  logic          wait_ph, wait_nxt;
  logic [TW-1:0] cnt;
  logic          ack_q;
  logic          ack_edge;
  logic          tmo;
  logic          accept;
  logic          cap_rd;
  logic [1:0]    err_nxt;
  logic          lat_rw;
  logic [6:0]    lat_chip;
  logic [7:0]    lat_reg;
  logic [7:0]    lat_wdata;

  assign ack_edge = tx_rx_req_ack & ~ack_q;
  assign tmo      = (cnt == TW'(TIMEOUT - 1));

  // Each command state spends one ISSUE cycle (wait_ph = 0, request low)
  // before WAIT, which guarantees a gap in tx_rx_req between commands.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_ph;
    err_nxt   = err;
    accept    = 1'b0;
    cap_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          err_nxt   = ERR_OK;
          state_nxt = START;
          wait_nxt  = 1'b0;
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        if (!wait_ph) begin
          wait_nxt = 1'b1;
        end else if (ack_edge) begin
          wait_nxt = 1'b0;
          case (state)
            START:  state_nxt = ADDR_W;
            ADDR_W: begin
              if (ack_nack_f) begin
                err_nxt   = ERR_ADDR;
                state_nxt = STOP;
              end else begin
                state_nxt = REG;
              end
            end
            REG: begin
              if (ack_nack_f) begin
                err_nxt   = ERR_DATA;
                state_nxt = STOP;
              end else begin
                state_nxt = (lat_rw == RW_READ) ? RSTART : DATA_W;
              end
            end
            DATA_W: begin
              if (ack_nack_f) err_nxt = ERR_DATA;
              state_nxt = STOP;
            end
            RSTART: state_nxt = ADDR_R;
            ADDR_R: begin
              if (ack_nack_f) begin
                err_nxt   = ERR_ADDR;
                state_nxt = STOP;
              end else begin
                state_nxt = READ;
              end
            end
            READ: begin
              cap_rd    = 1'b1;
              state_nxt = STOP;
            end
            STOP:    state_nxt = DONE;
            default: state_nxt = IDLE;
          endcase
        end else if (tmo) begin
          err_nxt   = ERR_TMO;
          wait_nxt  = 1'b0;
          state_nxt = DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_ph   <= 1'b0;
      cnt       <= '0;
      ack_q     <= 1'b0;
      err       <= ERR_OK;
      rd_data   <= 8'h00;
      comp      <= 10'h000;
      lat_rw    <= RW_WRITE;
      lat_chip  <= 7'h00;
      lat_reg   <= 8'h00;
      lat_wdata <= 8'h00;
    end else begin
      state   <= state_nxt;
      wait_ph <= wait_nxt;
      ack_q   <= tx_rx_req_ack;
      err     <= err_nxt;
      cnt     <= wait_ph ? cnt + TW'(1) : '0;
      if (cap_rd) rd_data <= rx_data;
      if (accept) begin
        comp      <= div;
        lat_rw    <= req_rw;
        lat_chip  <= req_chip;
        lat_reg   <= req_reg;
        lat_wdata <= req_wdata;
      end
    end
  end

  // Command strobes are only raised in WAIT, together with tx_rx_req.
  always_comb begin
    start_gen = 1'b0;
    stop_gen  = 1'b0;
    tr_gen    = 1'b0;
    rec_gen   = 1'b0;
    tx_data   = 8'h00;
    case (state)
      START, RSTART: start_gen = wait_ph;
      ADDR_W: begin
        tr_gen  = wait_ph;
        tx_data = {lat_chip, RW_WRITE};
      end
      REG: begin
        tr_gen  = wait_ph;
        tx_data = lat_reg;
      end
      DATA_W: begin
        tr_gen  = wait_ph;
        tx_data = lat_wdata;
      end
      ADDR_R: begin
        tr_gen  = wait_ph;
        tx_data = {lat_chip, RW_READ};
      end
      READ:    rec_gen  = wait_ph;
      STOP:    stop_gen = wait_ph;
      default: ;
    endcase
  end

  assign tx_rx_req = wait_ph;
  assign ack_nack  = (state == READ);
  assign req_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign tr_en     = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq: a stub master with an embedded memory slave,
// a command scoreboard and a completion scoreboard.
module tb_i2c_reg_seq;

  localparam int         TIMEOUT = 100;
  localparam logic [6:0] SLAVE   = 7'h18;
  localparam logic [3:0] K_START = 4'b1000;
  localparam logic [3:0] K_STOP  = 4'b0100;
  localparam logic [3:0] K_TR    = 4'b0010;
  localparam logic [3:0] K_REC   = 4'b0001;

  typedef enum int {M_NORM, M_NONE, M_HOLD, M_STALL} mode_t;
  typedef struct packed {
    logic [1:0] err;
    logic       chk_rd;
    logic [7:0] rd;
    logic [9:0] comp;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] div = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_chip = '0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       done;
  logic [1:0] err;
  logic [7:0] rd_data;
  logic [9:0] comp;
  logic       start_gen, stop_gen, tr_gen, rec_gen;
  logic [7:0] tx_data;
  logic       tr_en, ack_nack, tx_rx_req;
  logic [7:0] rxd = '0;
  logic       nack_f = 1'b0;
  logic       ack = 1'b0;

  int tests = 0, fails = 0;
  int cyc = 0, cmd_cnt = 0, done_cnt = 0, done_cyc = 0, accept_cyc = 0;
  logic [12:0] cmd_q[$];
  res_t        res_q[$];
  logic [7:0]  mem[256];
  int          byte_idx = 0;
  logic        addr_ok = 1'b0, rd_mode = 1'b0;
  logic [7:0]  ptr = '0;
  mode_t       mode = M_NORM;
  logic        prev_req = 1'b0;

  i2c_reg_seq #(.TIMEOUT(TIMEOUT), .TW(16)) dut (
    .clk(clk), .reset(reset), .div(div),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_chip(req_chip), .req_reg(req_reg), .req_wdata(req_wdata),
    .done(done), .err(err), .rd_data(rd_data), .comp(comp),
    .start_gen(start_gen), .stop_gen(stop_gen), .tr_gen(tr_gen), .rec_gen(rec_gen),
    .tx_data(tx_data), .tr_en(tr_en), .ack_nack(ack_nack), .tx_rx_req(tx_rx_req),
    .rx_data(rxd), .ack_nack_f(nack_f), .tx_rx_req_ack(ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic [3:0] k, input logic an, input logic [7:0] d);
    return {k, an, d};
  endfunction

  // Stub master plus memory slave at SLAVE; acks one cycle after a request.
  always @(negedge clk) begin
    if (reset) begin
      ack = 1'b0;
      nack_f = 1'b0;
      byte_idx = 0;
    end else if (mode == M_NONE) begin
      ack = 1'b0;
    end else if (mode == M_HOLD) begin
      ack = 1'b1;
    end else if (tx_rx_req && !ack && !(mode == M_STALL && tr_gen && byte_idx == 1)) begin
      ack = 1'b1;
      if (start_gen) byte_idx = 0;
      if (tr_gen) begin
        if (byte_idx == 0) begin
          addr_ok = (tx_data[7:1] == SLAVE);
          rd_mode = tx_data[0];
        end else if (!rd_mode && addr_ok) begin
          if (byte_idx == 1) ptr = tx_data;
          else begin
            mem[ptr] = tx_data;
            ptr = ptr + 8'd1;
          end
        end
        nack_f = !addr_ok;
        byte_idx++;
      end
      if (rec_gen) begin
        rxd = mem[ptr];
        ptr = ptr + 8'd1;
      end
    end else begin
      ack = 1'b0;
    end
  end

  // Scoreboard side: every new request and every done pulse is compared.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_rx_req && !prev_req) begin
        cmd_cnt++;
        check("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0)
          check("cmd", {start_gen, stop_gen, tr_gen, rec_gen, ack_nack,
                        tr_gen ? tx_data : 8'h00}, cmd_q.pop_front());
      end
      if (done) begin
        res_t r;
        done_cnt++;
        done_cyc = cyc;
        check("done_expected", res_q.size() != 0, 1);
        check("done_req_low", tx_rx_req, 0);
        check("done_tr_en_low", tr_en, 0);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check("err", err, r.err);
          check("comp", comp, r.comp);
          if (r.chk_rd) check("rd_data", rd_data, r.rd);
        end
      end
    end
    prev_req = tx_rx_req;
  end

  task automatic exp_res(input logic [1:0] e, input logic chk, input logic [7:0] rd,
                         input logic [9:0] dv);
    res_t r;
    r.err = e; r.chk_rd = chk; r.rd = rd; r.comp = dv;
    res_q.push_back(r);
  endtask

  task automatic exp_write(input logic [6:0] chip, input logic [7:0] rg, input logic [7:0] wd);
    cmd_q.push_back(mk(K_START, 1'b0, 8'h00));
    cmd_q.push_back(mk(K_TR, 1'b0, {chip, 1'b0}));
    cmd_q.push_back(mk(K_TR, 1'b0, rg));
    cmd_q.push_back(mk(K_TR, 1'b0, wd));
    cmd_q.push_back(mk(K_STOP, 1'b0, 8'h00));
  endtask

  task automatic send_req(input logic rw, input logic [6:0] chip, input logic [7:0] rg,
                          input logic [7:0] wd, input logic [9:0] dv);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_rw = rw; req_chip = chip; req_reg = rg; req_wdata = wd; div = dv;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    req_valid = 1'b0;
    req_rw = ~rw; req_chip = ~chip; req_reg = ~rg; req_wdata = ~wd; div = ~dv;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", done_cnt != start, 1);
  endtask

  initial begin
    int c0;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_tx_rx_req", tx_rx_req, 0);
    check("rst_tr_en", tr_en, 0);
    check("rst_done", done, 0);
    check("rst_comp", comp, 0);
    check("rst_gens", {start_gen, stop_gen, tr_gen, rec_gen}, 0);
    reset = 1'b0;

    exp_write(SLAVE, 8'h05, 8'hA7);
    exp_res(2'd0, 1'b0, 8'h00, 10'h0C8);
    send_req(1'b0, SLAVE, 8'h05, 8'hA7, 10'h0C8);
    wait_done(60);
    check("mem5_written", mem[5], 8'hA7);

    cmd_q.push_back(mk(K_START, 1'b0, 8'h00));
    cmd_q.push_back(mk(K_TR, 1'b0, 8'h30));
    cmd_q.push_back(mk(K_TR, 1'b0, 8'h05));
    cmd_q.push_back(mk(K_START, 1'b0, 8'h00));
    cmd_q.push_back(mk(K_TR, 1'b0, 8'h31));
    cmd_q.push_back(mk(K_REC, 1'b1, 8'h00));
    cmd_q.push_back(mk(K_STOP, 1'b0, 8'h00));
    exp_res(2'd0, 1'b1, 8'hA7, 10'h064);
    send_req(1'b1, SLAVE, 8'h05, 8'h00, 10'h064);
    wait_done(80);

    c0 = cmd_cnt;
    cmd_q.push_back(mk(K_START, 1'b0, 8'h00));
    cmd_q.push_back(mk(K_TR, 1'b0, 8'h44));
    cmd_q.push_back(mk(K_STOP, 1'b0, 8'h00));
    exp_res(2'd1, 1'b0, 8'h00, 10'h3FF);
    send_req(1'b0, 7'h22, 8'h05, 8'h11, 10'h3FF);
    wait_done(60);
    check("absent_cmd_count", cmd_cnt - c0, 3);
    repeat (3) @(posedge clk);
    check("err_held", err, 2'd1);

    mode = M_NONE;
    cmd_q.push_back(mk(K_START, 1'b0, 8'h00));
    exp_res(2'd3, 1'b0, 8'h00, 10'h001);
    send_req(1'b0, SLAVE, 8'h06, 8'h22, 10'h001);
    wait_done(TIMEOUT + 50);
    check("timeout_latency", done_cyc - accept_cyc, TIMEOUT + 1);
    mode = M_NORM;

    mode = M_STALL;
    cmd_q.push_back(mk(K_START, 1'b0, 8'h00));
    cmd_q.push_back(mk(K_TR, 1'b0, 8'h30));
    cmd_q.push_back(mk(K_TR, 1'b0, 8'h05));
    send_req(1'b0, SLAVE, 8'h05, 8'h99, 10'h010);
    c0 = 0;
    while (!(tx_rx_req && tr_gen && tx_data == 8'h05) && c0 < 50) begin
      @(negedge clk);
      c0++;
    end
    check("reg_wait_reached", tx_rx_req && tr_gen && tx_data == 8'h05, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_req", tx_rx_req, 0);
    check("rst_mid_tr_en", tr_en, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_cmds_drained", cmd_q.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mode = M_NORM;
    exp_write(SLAVE, 8'h09, 8'h5A);
    exp_res(2'd0, 1'b0, 8'h00, 10'h020);
    send_req(1'b0, SLAVE, 8'h09, 8'h5A, 10'h020);
    wait_done(60);
    check("mem9_written", mem[9], 8'h5A);
    check("mem5_untouched", mem[5], 8'hA7);

    mode = M_HOLD;
    c0 = cmd_cnt;
    d0 = done_cnt;
    exp_write(SLAVE, 8'h07, 8'h3C);
    exp_res(2'd0, 1'b0, 8'h00, 10'h155);
    send_req(1'b0, SLAVE, 8'h07, 8'h3C, 10'h155);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("hold_still_start", {tx_rx_req, start_gen}, 2'b11);
    check("hold_no_done", done_cnt - d0, 0);
    #1 mode = M_NORM;
    wait_done(60);
    check("hold_cmd_count", cmd_cnt - c0, 5);
    check("mem7_written", mem[7], 8'h3C);

    repeat (2) @(posedge clk);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
